// File: rtl/mem_test_ctrl.sv
// Command sequencer for the memory checker: walks a strided address range
// and tracks read checks. MEM_TEST_ERR_CAPTURE_EN adds err_addr_o capture.
module mem_test_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              stop_on_err_i,
  output logic              cmd_valid_o,
  output logic              cmd_we_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  input  logic              cmd_ready_i,
  input  logic              cmp_valid_i,
  input  logic              cmp_ok_i,
`ifdef MEM_TEST_ERR_CAPTURE_EN
  output logic [ADDR_W-1:0] err_addr_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, WR_BURST, RD_BURST, WR_WORD,
    RD_WORD, WAIT_CHK, DRAIN, DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              start_q;
  logic              rise_q;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] stride;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  left;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  outst_nxt;
  logic              soe;

  logic acc;
  logic rd_acc;
  logic cmp_hit;
  logic fail;
  logic abort;

  // only modes 10/11 check reads; mode[1] marks them
  assign acc     = cmd_valid_o & cmd_ready_i;
  assign rd_acc  = acc & ~cmd_we_o & mode[1];
  assign cmp_hit = cmp_valid_i & mode[1] & (outst != '0);
  assign fail    = cmp_hit & ~cmp_ok_i;
  assign abort   = fail & soe;

  always_comb begin
    outst_nxt = outst;
    if (rd_acc && !cmp_hit)
      outst_nxt = outst + ONE;
    else if (!rd_acc && cmp_hit)
      outst_nxt = outst - ONE;
  end

  // start_q runs through reset so a held start is not seen as an edge
  always_ff @(posedge clk_i) begin
    start_q <= start_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rise_q      <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_we_o    <= 1'b0;
      cmd_addr_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
      outst       <= '0;
      left        <= '0;
      mode        <= 2'b00;
      base        <= '0;
      stride      <= '0;
      cnt         <= '0;
      soe         <= 1'b0;
    end else begin
      rise_q <= start_i & ~start_q;
      done_o <= 1'b0;
      outst  <= outst_nxt;
      if (fail) begin
        err_o <= 1'b1;
        if (err_cnt_o != '1)
          err_cnt_o <= err_cnt_o + ONE;
      end
      unique case (state)
        IDLE: if (rise_q) begin
          mode       <= mode_i;
          base       <= base_addr_i;
          stride     <= stride_i;
          cnt        <= cnt_i;
          soe        <= stop_on_err_i;
          err_o      <= 1'b0;
          err_cnt_o  <= '0;
          busy_o     <= 1'b1;
          cmd_addr_o <= base_addr_i;
          left       <= cnt_i - ONE;
          if (cnt_i == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            cmd_valid_o <= 1'b1;
            unique case (mode_i)
              2'b01: begin
                state    <= RD_BURST;
                cmd_we_o <= 1'b0;
              end
              2'b10: begin
                state    <= WR_WORD;
                cmd_we_o <= 1'b1;
              end
              default: begin
                state    <= WR_BURST;
                cmd_we_o <= 1'b1;
              end
            endcase
          end
        end
        WR_BURST: if (acc) begin
          if (left != '0) begin
            cmd_addr_o <= cmd_addr_o + stride;
            left       <= left - ONE;
          end else if (mode == 2'b11) begin
            state      <= RD_BURST;
            cmd_we_o   <= 1'b0;
            cmd_addr_o <= base;
            left       <= cnt - ONE;
          end else begin
            cmd_valid_o <= 1'b0;
            state       <= DONE;
            done_o      <= 1'b1;
          end
        end
        RD_BURST: begin
          if (abort) begin
            cmd_valid_o <= 1'b0;
            state       <= DRAIN;
          end else if (acc) begin
            if (left != '0) begin
              cmd_addr_o <= cmd_addr_o + stride;
              left       <= left - ONE;
            end else begin
              cmd_valid_o <= 1'b0;
              state       <= DRAIN;
            end
          end
        end
        WR_WORD: if (acc) begin
          cmd_we_o <= 1'b0;
          state    <= RD_WORD;
        end
        RD_WORD: if (acc) begin
          cmd_valid_o <= 1'b0;
          state       <= WAIT_CHK;
        end
        WAIT_CHK: if (cmp_hit) begin
          if (!abort && left != '0) begin
            left        <= left - ONE;
            cmd_addr_o  <= cmd_addr_o + stride;
            cmd_we_o    <= 1'b1;
            cmd_valid_o <= 1'b1;
            state       <= WR_WORD;
          end else begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DRAIN: if (outst_nxt == '0) begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_TEST_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] trk [2**CNT_W];
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;

  always_ff @(posedge clk_i) begin
    if (rd_acc)
      trk[wr_ptr] <= cmd_addr_o;
  end

  // checks return in issue order, so the head is the failing read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_addr_o <= '0;
    end else begin
      if (rd_acc)
        wr_ptr <= wr_ptr + ONE;
      if (cmp_hit)
        rd_ptr <= rd_ptr + ONE;
      if (state == IDLE && rise_q)
        err_addr_o <= '0;
      else if (fail && !err_o)
        err_addr_o <= trk[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Directed bench for mem_test_ctrl with a transaction-level model
// and a per-cycle compare process.
module tb_mem_test_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [15:0] cnt_i = '0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] stride_i = '0;
  logic        stop_on_err_i = 1'b0;
  logic        cmd_valid_o;
  logic        cmd_we_o;
  logic [31:0] cmd_addr_o;
  logic        cmd_ready_i;
  logic        cmp_valid_i;
  logic        cmp_ok_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] err_cnt_o;
`ifdef MEM_TEST_ERR_CAPTURE_EN
  logic [31:0] err_addr;
`endif

  mem_test_ctrl dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .mode_i(mode_i),
    .cnt_i(cnt_i),
    .base_addr_i(base_addr_i),
    .stride_i(stride_i),
    .stop_on_err_i(stop_on_err_i),
    .cmd_valid_o(cmd_valid_o),
    .cmd_we_o(cmd_we_o),
    .cmd_addr_o(cmd_addr_o),
    .cmd_ready_i(cmd_ready_i),
    .cmp_valid_i(cmp_valid_i),
    .cmp_ok_i(cmp_ok_i),
`ifdef MEM_TEST_ERR_CAPTURE_EN
    .err_addr_o(err_addr),
`endif
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // model state
  logic        exp_we[$];
  logic [31:0] exp_addr[$];
  logic [1:0]  tmode = 2'b00;
  bit          m_soe = 0;
  bit          m_abort_seen = 0;
  int          m_out = 0;
  int          m_errs = 0;
  bit          err_chk_en = 0;

  // stimulus knobs
  bit rdy_toggle = 0;
  bit force_cmp = 0;
  int fail_lo = 1000;
  int fail_hi = 1000;
  int chk_idx = 0;
  bit rd_acc_seen = 0;

  // observations
  int ncyc = 0;
  int n_acc, n_rd, n_hit;
  int first_valid_neg, last_acc_neg, done_neg;
  int last_cmp_neg, done_seen, start_neg;
  logic [31:0] last_acc_addr;
  bit prev_hold = 0, prev_rst = 1, prev_abort = 0, prev_done = 0;
  logic prev_we;
  logic [31:0] prev_addr;

  // memory-side responder: ready pattern plus checks 3 cycles after reads
  initial begin
    logic [2:0] dl;
    dl = '0;
    cmd_ready_i = 1'b1;
    cmp_valid_i = 1'b0;
    cmp_ok_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cmd_ready_i = rdy_toggle ? ~cmd_ready_i : 1'b1;
      dl = rst_i ? 3'b000 : {dl[1:0], rd_acc_seen};
      if (force_cmp) begin
        cmp_valid_i = 1'b1;
        cmp_ok_i = 1'b0;
      end else begin
        cmp_valid_i = dl[2];
        cmp_ok_i = !(chk_idx >= fail_lo && chk_idx <= fail_hi);
        if (dl[2]) chk_idx++;
      end
    end
  end

  always @(negedge clk) begin
    logic acc, hit, abort_evt;
    ncyc++;
    if (err_chk_en) begin
      chk("err_cnt", err_cnt_o, m_errs);
      chk("err_flag", err_o, m_errs != 0);
    end
    if (done_o === 1'b1) begin
      chk("busy_with_done", busy_o, 1);
      chk("done_pulse_width", prev_done, 0);
      done_seen++;
      done_neg = ncyc;
    end
    if (prev_hold && !prev_rst && !prev_abort) begin
      chk("hold_valid", cmd_valid_o, 1);
      chk("hold_we", cmd_we_o, prev_we);
      chk("hold_addr", cmd_addr_o, prev_addr);
    end
    acc = (cmd_valid_o === 1'b1) && (cmd_ready_i === 1'b1);
    if (cmd_valid_o === 1'b1 && first_valid_neg < 0)
      first_valid_neg = ncyc;
    if (acc) begin
      chk("cmd_after_abort", m_abort_seen, 0);
      if (tmode == 2'b10 && cmd_we_o)
        chk("write_with_read_pending", m_out, 0);
      if (exp_we.size() == 0)
        chk("extra_cmd", acc, 0);
      else begin
        chk("cmd_we", cmd_we_o, exp_we.pop_front());
        chk("cmd_addr", cmd_addr_o, exp_addr.pop_front());
      end
      n_acc++;
      if (!cmd_we_o) n_rd++;
      last_acc_neg = ncyc;
      last_acc_addr = cmd_addr_o;
    end
    abort_evt = 0;
    if (rst_i) begin
      m_out = 0;
      m_errs = 0;
      m_abort_seen = 0;
    end else begin
      hit = (cmp_valid_i === 1'b1) && tmode[1] && (m_out > 0);
      if (hit) begin
        n_hit++;
        last_cmp_neg = ncyc;
        if (!cmp_ok_i) begin
          if (m_errs < 65535) m_errs++;
          if (m_soe) begin
            m_abort_seen = 1;
            abort_evt = 1;
          end
        end
        m_out--;
      end
      if (acc && !cmd_we_o && tmode[1]) m_out++;
    end
    rd_acc_seen = acc && !cmd_we_o && !rst_i;
    prev_hold = (cmd_valid_o === 1'b1) && (cmd_ready_i === 1'b0);
    prev_we = cmd_we_o;
    prev_addr = cmd_addr_o;
    prev_rst = rst_i;
    prev_abort = abort_evt;
    prev_done = (done_o === 1'b1);
  end

  task automatic load_exp(logic [1:0] m, int n,
                          logic [31:0] b, logic [31:0] s);
    logic [31:0] a;
    exp_we.delete();
    exp_addr.delete();
    if (m == 2'b10) begin
      for (int k = 0; k < n; k++) begin
        a = b + s * k;
        exp_we.push_back(1'b1); exp_addr.push_back(a);
        exp_we.push_back(1'b0); exp_addr.push_back(a);
      end
    end else begin
      if (m != 2'b01)
        for (int k = 0; k < n; k++) begin
          a = b + s * k;
          exp_we.push_back(1'b1); exp_addr.push_back(a);
        end
      if (m != 2'b00)
        for (int k = 0; k < n; k++) begin
          a = b + s * k;
          exp_we.push_back(1'b0); exp_addr.push_back(a);
        end
    end
  endtask

  task automatic start_test(logic [1:0] m, int n,
                            logic [31:0] b, logic [31:0] s,
                            bit soe, bit tog, int flo, int fhi);
    load_exp(m, n, b, s);
    tmode = m;
    m_soe = soe;
    m_abort_seen = 0;
    rdy_toggle = tog;
    fail_lo = flo;
    fail_hi = fhi;
    chk_idx = 0;
    n_acc = 0; n_rd = 0; n_hit = 0;
    first_valid_neg = -1; last_acc_neg = -1;
    done_neg = -1; last_cmp_neg = -1; done_seen = 0;
    err_chk_en = 0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    mode_i = m;
    cnt_i = n[15:0];
    base_addr_i = b;
    stride_i = s;
    stop_on_err_i = soe;
    start_i = 1'b1;
    start_neg = ncyc + 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("busy_before_accept", busy_o, 0);
    m_errs = 0;
    err_chk_en = 1;
    @(negedge clk);
    #1;
    chk("busy_after_accept", busy_o, 1);
    // descriptor must be latched, so scramble the inputs
    base_addr_i = 32'hDEAD_BEEF;
    stride_i = 32'h1;
    mode_i = ~m;
    cnt_i = 16'h7;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && done_seen == 0; i++)
      @(posedge clk);
    chk("done_seen", done_seen != 0, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("single_done", done_seen, 1);
    chk("busy_after_done", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_we", cmd_we_o, 0);
    chk("rst_addr", cmd_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    err_chk_en = 1;

    // mode 00 burst, ready high
    start_test(2'b00, 4, 32'h100, 32'h4, 0, 0, 1000, 1000);
    wait_done(100);
    chk("t1_first_valid_lat", first_valid_neg - start_neg, 2);
    chk("t1_n_acc", n_acc, 4);
    chk("t1_span", last_acc_neg - first_valid_neg, 3);
    chk("t1_done_lat", done_neg - last_acc_neg, 1);
    chk("t1_last_addr", last_acc_addr, 32'h10C);
    chk("t1_left", exp_we.size(), 0);

    // mode 11 with ready toggling, all checks ok
    start_test(2'b11, 3, 32'h2000, 32'h8, 0, 1, 1000, 1000);
    wait_done(200);
    chk("t2_n_acc", n_acc, 6);
    chk("t2_n_rd", n_rd, 3);
    chk("t2_n_hit", n_hit, 3);
    chk("t2_done_after_chk", done_neg > last_cmp_neg, 1);
    chk("t2_left", exp_we.size(), 0);
    chk("t2_err_cnt", err_cnt_o, 0);

    // mode 10, second check fails, keep going
    start_test(2'b10, 2, 32'h40, 32'h10, 0, 0, 1, 1);
    wait_done(200);
    chk("t3_n_acc", n_acc, 4);
    chk("t3_err", err_o, 1);
    chk("t3_err_cnt", err_cnt_o, 1);
    chk("t3_left", exp_we.size(), 0);

    // mode 11 stop on error: check 1 onwards fail
    start_test(2'b11, 8, 32'h0, 32'h4, 1, 0, 1, 1000);
    wait_done(200);
    chk("t4_n_rd", n_rd, 5);
    chk("t4_err_cnt", err_cnt_o, 4);
    chk("t4_err", err_o, 1);
    chk("t4_left", exp_we.size(), 3);

    // mode 01 wrap; responder fails everything, must be ignored
    start_test(2'b01, 2, 32'hFFFF_FFFC, 32'h4, 0, 0, 0, 1000);
    wait_done(100);
    chk("t5_n_acc", n_acc, 2);
    chk("t5_wrap_addr", last_acc_addr, 32'h0);
    chk("t5_err", err_o, 0);
    chk("t5_left", exp_we.size(), 0);

    // cnt = 0
    start_test(2'b10, 0, 32'h500, 32'h4, 0, 0, 1000, 1000);
    wait_done(50);
    chk("t6_done_lat", done_neg - start_neg, 2);
    chk("t6_n_acc", n_acc, 0);

    // stray check result while idle
    @(posedge clk); #1;
    force_cmp = 1;
    repeat (2) @(posedge clk);
    #1;
    force_cmp = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_idle_err", err_o, 0);
    chk("t7_idle_err_cnt", err_cnt_o, 0);

    // start edge while busy is ignored
    start_test(2'b11, 3, 32'h800, 32'h4, 0, 0, 1000, 1000);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    wait_done(100);
    repeat (10) @(posedge clk);
    #1;
    chk("t8_no_restart_busy", busy_o, 0);
    chk("t8_n_acc", n_acc, 6);
    chk("t8_left", exp_we.size(), 0);

    // reset mid-burst
    start_test(2'b00, 8, 32'h300, 32'h4, 0, 0, 1000, 1000);
    for (int i = 0; i < 50 && n_acc < 3; i++)
      @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    #1;
    chk("t9_valid", cmd_valid_o, 0);
    chk("t9_we", cmd_we_o, 0);
    chk("t9_addr", cmd_addr_o, 0);
    chk("t9_busy", busy_o, 0);
    chk("t9_done", done_o, 0);
    chk("t9_err", err_o, 0);
    chk("t9_err_cnt", err_cnt_o, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("t9_valid_after", cmd_valid_o, 0);
    chk("t9_busy_after", busy_o, 0);
    chk("t9_no_done", done_seen, 0);
    exp_we.delete();
    exp_addr.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
